ddr4_cmd_scheduler: RTL and testbench
=====================================

// Module: ddr4_cmd_scheduler
// PURPOSE
// - Sequences DDR4 commands for two host requesters (read port, write port) over one shared command bus.
// - Does power-up tMOD wait, round-robin arbitration, per-bank open-row tracking, and ACT/PRE/RD/WR issue.
// - Enforces tRCD, tCCD and tRP between commands.
// - Sits between the host request logic and the DDR4 command/address drivers; clocked by the divided CK_t.
// PARAMETERS
// tMOD   5  CK_t cycles after reset before first command; ready=0 until then
// tRCD   5  min cycles ACT -> RD/WR, same bank
// tCCD   5  min cycles RD/WR -> next command of any kind
// tRP    5  min cycles PRE -> ACT, same bank
// BA_W   2  bank address width (2^BA_W banks tracked)
// ROW_W  4  row address width
// COL_W  4  column address width (COL_W <= ROW_W)
// PORTS
// CK_t      in   1               controller clock; all logic on posedge
// rst       in   1               synchronous, active-high reset
// rd_req    in   1               read request; held until rd_ack
// rd_addr   in   BA_W+ROW_W+COL_W {bank,row,col}; sampled at grant only
// rd_ack    out  1               1-cycle pulse, same cycle RD is issued
// wr_req    in   1               write request; held until wr_ack
// wr_addr   in   BA_W+ROW_W+COL_W {bank,row,col}; sampled at grant only
// wr_ack    out  1               1-cycle pulse, same cycle WR is issued
// cmd       out  3               NOP=0, ACT=1, RD=2, WR=3, PRE=4; non-NOP for exactly 1 cycle
// cmd_ba    out  BA_W            bank for cmd; 0 when cmd=NOP
// cmd_addr  out  ROW_W           row on ACT; zero-extended col on RD/WR; 0 on PRE/NOP
// ready     out  1               1 once tMOD has elapsed; stays 1 until reset
// busy      out  1               1 in every state except IDLE
// BEHAVIOUR
// - Reset (any cycle, incl. mid-transaction): state=INIT, all outputs 0, timer=0, every bank closed,
//   last_grant=WR so read wins first tie. An in-flight request is dropped: no ack is given.
// - States: INIT, IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, CAS, CAS_WAIT.
// - INIT: count tMOD cycles from reset deassertion. Enter IDLE on cycle tMOD with ready=1.
// - IDLE grant rules:
//   - Only one of rd_req/wr_req set: grant it.
//   - Both set: grant opposite of last_grant; update last_grant.
//   - Latch {bank,row,col} and direction at grant. Address changes afterwards are ignored.
// - Next state from granted bank:
//   - closed -> ACT
//   - open, same row (hit) -> CAS
//   - open, other row (miss) -> PRE
//   - Granting cycle issues no command, so grant-to-ack latency is 1 cycle on a hit.
// - PRE: cmd=PRE, mark bank closed; PRE_WAIT holds tRP-1 cycles; then ACT.
// - ACT: cmd=ACT, cmd_addr=row, mark bank open with row; ACT_WAIT holds tRCD-1 cycles; then CAS.
// - CAS: cmd=RD or WR, cmd_addr=col, matching ack=1; CAS_WAIT holds tCCD-1 cycles; then IDLE.
// - Spacing: next command issued exactly tX cycles after the previous one (tX = tRP/tRCD/tCCD).
// - Waits are counted by a down-counter loaded with tX-1 at issue; a load of 0 skips the wait state.
// - Bank state persists across transactions (open-page policy). No auto-precharge. No refresh.
// - Requests are ignored outside IDLE. A req dropped before grant is legal; no ack results.
// - rd_ack and wr_ack are never both 1. Acks are 0 in INIT.
// - Timer width is $clog2(max(tMOD,tRCD,tCCD,tRP)+1).
// - Parameter value 0 is illegal; flag it with an elaboration-time check.
// STRUCTURE
// - ddr4_pkg: cmd encodings (CMD_NOP..CMD_PRE), state enum, default timing constants.
//   Shared with MC-level and driver blocks.
// - Sub-module ddr4_timer: loadable down-counter with load, value and zero outputs; one instance.
// - Bank table (open bit + row per bank) and arbiter live inline.
// TESTING
// 1 Reset release, no reqs -> ready rises on cycle 5; cmd=NOP throughout; busy=0 in IDLE.
// 2 rd_req bank1/row9/col4 to closed bank:
//   - ACT(ba=1,addr=9) at T, RD(ba=1,addr=4) at T+5 with rd_ack, busy clears at T+10.
// 3 Then wr_req bank1/row9/col2 (row hit):
//   - grant cycle G, WR(ba=1,addr=2) at G+1 with wr_ack; no ACT.
// 4 Then rd_req bank1/row6 (row miss):
//   - PRE(ba=1) at T, ACT(row6) at T+5, RD at T+10.
// 5 rd_req and wr_req both held, different banks, from first IDLE:
//   - RD acked first, then WR; over 4 ties the grants alternate R,W,R,W.
// 6 Assert rst for 1 cycle during ACT_WAIT:
//   - no ack issued; ready=0 for 5 cycles; a re-sent request to the same bank issues ACT (bank closed).

Source files
------------

// File: rtl/ddr4_pkg.sv
// Shared DDR4 command encodings, scheduler states and default timing constants.
package ddr4_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_ACT_WAIT,
    ST_CAS,
    ST_CAS_WAIT
  } state_e;

  localparam int T_MOD_DEF = 5;
  localparam int T_RCD_DEF = 5;
  localparam int T_CCD_DEF = 5;
  localparam int T_RP_DEF  = 5;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ddr4_timer.sv
// Loadable down-counter for inter-command spacing; load takes effect next cycle,
// then counts down by one per cycle and holds at zero.
module ddr4_timer #(
  parameter int TW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic [TW-1:0] value_o,
  output logic          zero_o
);

  logic [TW-1:0] value_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= load_val_i;
    end else if (value_q != '0) begin
      value_q <= value_q - TW'(1);
    end
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/ddr4_cmd_scheduler.sv
// Round-robin DDR4 command sequencer for one read and one write requester (open-page policy).
// Grant in IDLE costs one cycle; requests are held by the host until acked and ignored outside IDLE.
module ddr4_cmd_scheduler
  import ddr4_pkg::*;
#(
  parameter int tMOD  = T_MOD_DEF,
  parameter int tRCD  = T_RCD_DEF,
  parameter int tCCD  = T_CCD_DEF,
  parameter int tRP   = T_RP_DEF,
  parameter int BA_W  = 2,
  parameter int ROW_W = 4,
  parameter int COL_W = 4
) (
  input  logic                        CK_t,
  input  logic                        rst,
  input  logic                        rd_req,
  input  logic [BA_W+ROW_W+COL_W-1:0] rd_addr,
  output logic                        rd_ack,
  input  logic                        wr_req,
  input  logic [BA_W+ROW_W+COL_W-1:0] wr_addr,
  output logic                        wr_ack,
  output logic [2:0]                  cmd,
  output logic [BA_W-1:0]             cmd_ba,
  output logic [ROW_W-1:0]            cmd_addr,
  output logic                        ready,
  output logic                        busy
);

  localparam int AW = BA_W + ROW_W + COL_W;
  localparam int NB = 1 << BA_W;
  localparam int TW = $clog2(max4(tMOD, tRCD, tCCD, tRP) + 1);

  if (tMOD < 1 || tRCD < 1 || tCCD < 1 || tRP < 1 ||
      BA_W < 1 || ROW_W < 1 || COL_W < 1 || COL_W > ROW_W) begin : g_param_check
    $error("ddr4_cmd_scheduler: illegal parameter value");
  end

  state_e            state_q, state_d;
  logic              ready_q;
  logic [TW-1:0]     init_cnt_q;
  logic              last_wr_q;
  logic              dir_wr_q;
  logic [BA_W-1:0]   ba_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [NB-1:0]     open_q;
  logic [ROW_W-1:0]  open_row_q [NB];

  logic              grant, gnt_wr;
  logic [AW-1:0]     gnt_addr;
  logic [BA_W-1:0]   gnt_ba;
  logic [ROW_W-1:0]  gnt_row;
  logic [COL_W-1:0]  gnt_col;
  logic              tmr_load, tmr_zero;
  logic [TW-1:0]     tmr_load_val, tmr_val;
  logic              init_done, wait_done;

  // Write wins only when alone or when read was granted last.
  assign gnt_wr    = wr_req && (!rd_req || !last_wr_q);
  assign gnt_addr  = gnt_wr ? wr_addr : rd_addr;
  assign gnt_ba    = gnt_addr[AW-1 -: BA_W];
  assign gnt_row   = gnt_addr[ROW_W+COL_W-1 -: ROW_W];
  assign gnt_col   = gnt_addr[COL_W-1:0];
  assign init_done = (init_cnt_q == TW'(tMOD - 1));
  // Wait state is entered holding tX-1 and left on its last cycle, so the next command lands tX after issue.
  assign wait_done = tmr_zero || (tmr_val == TW'(1));

  ddr4_timer #(.TW(TW)) u_timer (
    .clk_i      (CK_t),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .value_o    (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      ST_INIT: if (init_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (rd_req || wr_req) begin
          grant = 1'b1;
          if (!open_q[gnt_ba])                    state_d = ST_ACT;
          else if (open_row_q[gnt_ba] == gnt_row) state_d = ST_CAS;
          else                                    state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        tmr_load     = 1'b1;
        tmr_load_val = TW'(tRP - 1);
        state_d      = (tRP == 1) ? ST_ACT : ST_PRE_WAIT;
      end
      ST_PRE_WAIT: if (wait_done) state_d = ST_ACT;
      ST_ACT: begin
        tmr_load     = 1'b1;
        tmr_load_val = TW'(tRCD - 1);
        state_d      = (tRCD == 1) ? ST_CAS : ST_ACT_WAIT;
      end
      ST_ACT_WAIT: if (wait_done) state_d = ST_CAS;
      ST_CAS: begin
        tmr_load     = 1'b1;
        tmr_load_val = TW'(tCCD - 1);
        state_d      = (tCCD == 1) ? ST_IDLE : ST_CAS_WAIT;
      end
      ST_CAS_WAIT: if (wait_done) state_d = ST_IDLE;
      default:     state_d = ST_INIT;
    endcase
  end

  always_comb begin
    cmd      = CMD_NOP;
    cmd_ba   = '0;
    cmd_addr = '0;
    rd_ack   = 1'b0;
    wr_ack   = 1'b0;
    case (state_q)
      ST_PRE: begin
        cmd    = CMD_PRE;
        cmd_ba = ba_q;
      end
      ST_ACT: begin
        cmd      = CMD_ACT;
        cmd_ba   = ba_q;
        cmd_addr = row_q;
      end
      ST_CAS: begin
        cmd      = dir_wr_q ? CMD_WR : CMD_RD;
        cmd_ba   = ba_q;
        cmd_addr = ROW_W'(col_q);
        rd_ack   = !dir_wr_q;
        wr_ack   = dir_wr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK_t) begin
    if (rst) begin
      state_q    <= ST_INIT;
      ready_q    <= 1'b0;
      init_cnt_q <= '0;
      last_wr_q  <= 1'b1;
      dir_wr_q   <= 1'b0;
      ba_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      open_q     <= '0;
      for (int b = 0; b < NB; b++) open_row_q[b] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        init_cnt_q <= init_cnt_q + TW'(1);
        if (init_done) ready_q <= 1'b1;
      end
      if (grant) begin
        last_wr_q <= gnt_wr;
        dir_wr_q  <= gnt_wr;
        ba_q      <= gnt_ba;
        row_q     <= gnt_row;
        col_q     <= gnt_col;
      end
      if (state_q == ST_PRE) open_q[ba_q] <= 1'b0;
      if (state_q == ST_ACT) begin
        open_q[ba_q]     <= 1'b1;
        open_row_q[ba_q] <= row_q;
      end
    end
  end

  assign ready = ready_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Bench for ddr4_cmd_scheduler: expected commands are queued at drive time and
// matched (command, bank, address, cycle, acks) as the DUT issues them.
module tb_ddr4_cmd_scheduler;

  logic       CK_t = 1'b0;
  logic       rst = 1'b1;
  logic       rd_req = 1'b0;
  logic       wr_req = 1'b0;
  logic [9:0] rd_addr = '0;
  logic [9:0] wr_addr = '0;
  logic       rd_ack, wr_ack, ready, busy;
  logic [2:0] cmd;
  logic [1:0] cmd_ba;
  logic [3:0] cmd_addr;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [2:0] c;
    logic [1:0] ba;
    logic [3:0] addr;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  ddr4_cmd_scheduler dut (
    .CK_t     (CK_t),
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_ack   (wr_ack),
    .cmd      (cmd),
    .cmd_ba   (cmd_ba),
    .cmd_addr (cmd_addr),
    .ready    (ready),
    .busy     (busy)
  );

  always #5 CK_t = ~CK_t;
  always @(posedge CK_t) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input int ba, input int addr, input int at);
    exp_t e;
    e.c    = 3'(c);
    e.ba   = 2'(ba);
    e.addr = 4'(addr);
    e.at   = at;
    sb.push_back(e);
  endfunction

  function automatic logic [9:0] mk_addr(input int ba, input int row, input int col);
    return {2'(ba), 4'(row), 4'(col)};
  endfunction

  always @(negedge CK_t) begin
    if (mon_en) begin
      if (cmd != 3'd0) begin
        if (sb.size() == 0) begin
          chk("unexpected_cmd", int'(cmd), 0);
        end else begin
          mon_e = sb.pop_front();
          chk("cmd", int'(cmd), int'(mon_e.c));
          chk("cmd_ba", int'(cmd_ba), int'(mon_e.ba));
          chk("cmd_addr", int'(cmd_addr), int'(mon_e.addr));
          chk("cmd_cycle", cyc, mon_e.at);
          chk("rd_ack", int'(rd_ack), int'(mon_e.c == 3'd2));
          chk("wr_ack", int'(wr_ack), int'(mon_e.c == 3'd3));
        end
      end else if (rd_ack || wr_ack) begin
        chk("stray_ack", int'({rd_ack, wr_ack}), 0);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge CK_t);
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; one reset edge, then the tMOD power-up window.
  task automatic reset_and_check();
    rst = 1'b1;
    @(negedge CK_t);
    chk("rst_ready", int'(ready), 0);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_ack", int'(rd_ack | wr_ack), 0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CK_t);
      chk("ready_rise", int'(ready), (i >= 5) ? 1 : 0);
    end
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CK_t);
      if (ready && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_ack(input bit wr);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CK_t);
      if (wr ? wr_ack : rd_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ack_timeout", 0, 1);
    if (wr) wr_req = 1'b0;
    else    rd_req = 1'b0;
  endtask

  initial begin
    int k, rn, wn;
    mon_en = 1'b1;

    // Power-up: ready after tMOD cycles, no commands.
    reset_and_check();

    // Read to a closed bank: ACT, RD tRCD later; address moves after grant are ignored.
    wait_idle();
    k = cyc;
    push(1, 1, 9, k + 1);
    push(2, 1, 4, k + 6);
    rd_addr = mk_addr(1, 9, 4);
    rd_req  = 1'b1;
    @(negedge CK_t);
    rd_addr = mk_addr(2, 15, 15);
    wait_ack(1'b0);
    repeat (4) @(negedge CK_t);
    chk("busy_cas_wait", int'(busy), 1);
    @(negedge CK_t);
    chk("busy_clear", int'(busy), 0);

    // Write row hit: WR one cycle after grant, no ACT.
    wait_idle();
    k = cyc;
    push(3, 1, 2, k + 1);
    wr_addr = mk_addr(1, 9, 2);
    wr_req  = 1'b1;
    wait_ack(1'b1);

    // Read row miss: PRE, ACT tRP later, RD tRCD after that.
    wait_idle();
    k = cyc;
    push(4, 1, 0, k + 1);
    push(1, 1, 6, k + 6);
    push(2, 1, 3, k + 11);
    rd_addr = mk_addr(1, 6, 3);
    rd_req  = 1'b1;
    wait_ack(1'b0);

    // Fresh reset, both ports held: four ties grant R,W,R,W, then a lone read.
    reset_and_check();
    k = cyc;
    push(1, 2, 1, k + 1);
    push(2, 2, 5, k + 6);
    push(1, 3, 2, k + 12);
    push(3, 3, 7, k + 17);
    push(2, 2, 6, k + 23);
    push(3, 3, 8, k + 29);
    push(2, 2, 7, k + 35);
    rd_addr = mk_addr(2, 1, 5);
    wr_addr = mk_addr(3, 2, 7);
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    rn = 0;
    wn = 0;
    for (int i = 0; i < 200 && !(rn == 3 && wn == 2); i++) begin
      @(negedge CK_t);
      if (rd_ack) begin
        rn++;
        if (rn == 1)      rd_addr = mk_addr(2, 1, 6);
        else if (rn == 2) rd_addr = mk_addr(2, 1, 7);
        else              rd_req  = 1'b0;
      end
      if (wr_ack) begin
        wn++;
        if (wn == 1) wr_addr = mk_addr(3, 2, 8);
        else         wr_req  = 1'b0;
      end
    end
    chk("tie_rd_acks", rn, 3);
    chk("tie_wr_acks", wn, 2);

    // Reset during ACT_WAIT: no ack, bank closed again afterwards.
    wait_idle();
    k = cyc;
    push(1, 0, 3, k + 1);
    rd_addr = mk_addr(0, 3, 1);
    rd_req  = 1'b1;
    repeat (2) @(negedge CK_t);
    rd_req = 1'b0;
    reset_and_check();
    k = cyc;
    push(1, 0, 3, k + 1);
    push(2, 0, 1, k + 6);
    rd_req = 1'b1;
    wait_ack(1'b0);

    repeat (8) @(negedge CK_t);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
